register_file: RTL

//   Parametrised multi-entry register file, successor to the single-register bank.
//   NUM_REGS x WIDTH storage, one write port, two registered read ports, plus a shadow

---
 rtl/register_file.sv | 83 ++++++++
 1 files changed

// File: rtl/register_file.sv
// ============================================================================
// Module      : register_file
// Description : NUM_REGS x WIDTH register file with one write port, two
//               registered read ports and a shadow bank for snapshot/restore.
//               Optional macro REGFILE_BYPASS_EN enables read-during-write
//               forwarding on both read ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_file #(
    parameter  int WIDTH    = 8,
    parameter  int NUM_REGS = 4,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [WIDTH-1:0]  rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_b,
    input  logic              snap,
    input  logic              restore
);

    logic [WIDTH-1:0]    r_regs   [NUM_REGS];
    logic [WIDTH-1:0]    r_shadow [NUM_REGS];
    logic [NUM_REGS-1:0] w_wr_hit;
    logic                w_wr_valid;
    logic [WIDTH-1:0]    w_rd_a;
    logic [WIDTH-1:0]    w_rd_b;

    // One-hot write decode; an out-of-range address matches no entry.
    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_wr_dec
            assign w_wr_hit[g] = wr_en && (wr_addr == ADDR_W'(g));
        end
    endgenerate

    assign w_wr_valid = |w_wr_hit;

    always_comb begin
        w_rd_a = '0;
        w_rd_b = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr_a == ADDR_W'(i)) w_rd_a = r_regs[i];
            if (rd_addr_b == ADDR_W'(i)) w_rd_b = r_regs[i];
        end
`ifdef REGFILE_BYPASS_EN
        if (w_wr_valid && (rd_addr_a == wr_addr)) w_rd_a = wr_data;
        if (w_wr_valid && (rd_addr_b == wr_addr)) w_rd_b = wr_data;
`else
        if (w_wr_valid && 1'b0) w_rd_a = wr_data;
`endif
    end

    // Restore is applied before the write so a same-cycle write wins;
    // snap samples pre-edge main values, giving an atomic swap with restore.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i]   <= '0;
                r_shadow[i] <= '0;
            end
            rd_data_a <= '0;
            rd_data_b <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (restore)     r_regs[i]   <= r_shadow[i];
                if (w_wr_hit[i]) r_regs[i]   <= wr_data;
                if (snap)        r_shadow[i] <= r_regs[i];
            end
            rd_data_a <= w_rd_a;
            rd_data_b <= w_rd_b;
        end
    end

endmodule

`default_nettype wire
